// File: rtl/fifo_core_ext.sv
// fifo_core_ext
//   Single-clock FIFO of 2^ALEN words x DLEN bits with selectable read mode
//   (standard registered read or first-word-fall-through), programmable
//   almost-full / almost-empty thresholds, occupancy count and synchronous
//   flush.
//
// Ports
//   clk, rstn      : clock (rising edge), synchronous active-low reset
//   i_flush        : synchronous flush, empties the FIFO
//   i_wen, i_wdata : write request and data
//   o_wfull        : level == DEPTH
//   o_wafull       : level >= AFULL_TH
//   o_woverflow    : one-cycle pulse after a write rejected while full
//   i_ren          : read request (standard) / pop of the head word (FWFT)
//   o_rdata        : read data
//   o_rempty       : no word available at the read side
//   o_raempty      : level <= AEMPTY_TH
//   o_runderflow   : one-cycle pulse after a read rejected while empty
//   o_level        : words held (accepted and not yet read)
module fifo_core_ext #(
    parameter int unsigned ALEN      = 8,
    parameter int unsigned DLEN      = 8,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AFULL_TH  = 2**ALEN - 2,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_flush,
    input  logic            i_wen,
    input  logic [DLEN-1:0] i_wdata,
    output logic            o_wfull,
    output logic            o_wafull,
    output logic            o_woverflow,
    input  logic            i_ren,
    output logic [DLEN-1:0] o_rdata,
    output logic            o_rempty,
    output logic            o_raempty,
    output logic            o_runderflow,
    output logic [ALEN:0]   o_level
);

    localparam int unsigned   DEPTH      = 2**ALEN;
    localparam logic [ALEN:0] DEPTH_LVL  = (ALEN+1)'(DEPTH);
    localparam logic [ALEN:0] AFULL_LVL  = (ALEN+1)'(AFULL_TH);
    localparam logic [ALEN:0] AEMPTY_LVL = (ALEN+1)'(AEMPTY_TH);
    localparam logic [ALEN:0] ONE        = {{ALEN{1'b0}}, 1'b1};

    logic [DLEN-1:0] mem [DEPTH];

    logic [ALEN:0] wptr;
    logic [ALEN:0] rptr;
    logic [ALEN:0] level;
    logic [ALEN:0] level_next;
    logic [ALEN:0] ram_count;
    logic          out_valid;
    logic          out_valid_next;
    logic          wr_acc;
    logic          rd_acc;
    logic          fetch;

    assign o_level = level;

    always_comb begin
        wr_acc         = i_wen & ~o_wfull;
        rd_acc         = i_ren & ~o_rempty;
        ram_count      = wptr - rptr;
        level_next     = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_next = level + ONE;
            2'b01:   level_next = level - ONE;
            default: level_next = level;
        endcase
        // In FWFT mode the output register is refilled from RAM whenever it
        // is empty or being popped, so a word becomes visible one cycle after
        // it lands in RAM. In standard mode the RAM is read only on a read.
        if (FWFT != 0) begin
            fetch = (ram_count != '0) && (!out_valid || rd_acc);
        end else begin
            fetch = rd_acc;
        end
        out_valid_next = fetch | (out_valid & ~rd_acc);
    end

    // Storage has no reset; a flush or reset only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (rstn && !i_flush && wr_acc) begin
            mem[wptr[ALEN-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            out_valid    <= 1'b0;
            o_rdata      <= '0;
            o_wfull      <= 1'b0;
            o_wafull     <= 1'b0;
            o_woverflow  <= 1'b0;
            o_rempty     <= 1'b1;
            o_raempty    <= 1'b1;
            o_runderflow <= 1'b0;
        end else if (i_flush) begin
            // o_rdata deliberately holds across a flush.
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            out_valid    <= 1'b0;
            o_wfull      <= 1'b0;
            o_wafull     <= 1'b0;
            o_woverflow  <= 1'b0;
            o_rempty     <= 1'b1;
            o_raempty    <= 1'b1;
            o_runderflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + ONE;
            end
            if (fetch) begin
                rptr    <= rptr + ONE;
                o_rdata <= mem[rptr[ALEN-1:0]];
            end
            level        <= level_next;
            out_valid    <= out_valid_next;
            o_wfull      <= (level_next == DEPTH_LVL);
            o_wafull     <= (level_next >= AFULL_LVL);
            o_raempty    <= (level_next <= AEMPTY_LVL);
            o_woverflow  <= i_wen & o_wfull;
            o_runderflow <= i_ren & o_rempty;
            if (FWFT != 0) begin
                o_rempty <= ~out_valid_next;
            end else begin
                o_rempty <= (level_next == '0);
            end
        end
    end

endmodule
